// File: rtl/spi_peripheral.sv
// ---------------------------------------------------------------------------
// spi_peripheral
//
// SPI Mode-0 target feeding the PWM control registers. sclk, copi and ncs are
// asynchronous to clk; they are oversampled through SYNC_STAGES-deep
// synchronizers, and only the synchronized copies are used internally.
//
// A frame is 16 bits, MSB first, sampled on synchronized sclk rising edges:
//   bit 15     R/W (1 = write)
//   bits 14:8  register address
//   bits 7:0   data
// A write commits on the synchronized ncs rising edge only when exactly 16
// bits were received, bit 15 is set and the address is <= MAX_ADDR.
//
// Build option:
//   SPI_READBACK_EN  when defined, read frames (bit 15 = 0) return the
//                    addressed register on cipo during the data phase.
//                    When undefined, cipo is tied low and no tx logic exists.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth per input (2..3)
//   MAX_ADDR     highest writable register address
//
// Ports:
//   clk              system clock (>= 8x sclk)
//   rst_n            asynchronous active-low reset
//   sclk, copi, ncs  SPI pins (asynchronous)
//   cipo             SPI target-out data
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
//
// FSM states
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | ncs high, sclk edges ignored, waiting for ncs to fall
//   ST_ACTIVE | frame in progress, shifting copi on each sclk rise
// ---------------------------------------------------------------------------
module spi_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL   = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_hist;
  logic                   ncs_hist;

  // Preset to the idle bus state so reset release never fakes an edge,
  // except a genuine ncs-low at release, which shows up as a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ncs_rise;
  logic ncs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  state_t      state;
  state_t      state_nxt;
  logic        frame_start;
  logic        frame_end;
  logic        shift_en;
  logic [15:0] shift_reg;
  logic [15:0] shift_nxt;
  logic [4:0]  bit_cnt;
  logic        commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ncs edges take priority over a coincident sclk rise.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    shift_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_nxt   = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ncs_rise) begin
          state_nxt = ST_IDLE;
          frame_end = 1'b1;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign shift_nxt = {shift_reg[14:0], copi_s};

  // Counter saturates at 17 so an overlong frame stays distinguishable
  // from a well-formed one no matter how many extra bits arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (frame_start) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_nxt;
      if (bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  assign commit = frame_end && (bit_cnt == CNT_FULL) && shift_reg[15] &&
                  (shift_reg[14:8] <= MAX_ADDR_L);

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  assign wr_addr = shift_reg[14:8];
  assign wr_data = shift_reg[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else if (commit) begin
      case (wr_addr)
        7'd0:    en_reg_out_7_0  <= wr_data;
        7'd1:    en_reg_out_15_8 <= wr_data;
        7'd2:    en_reg_pwm_7_0  <= wr_data;
        7'd3:    en_reg_pwm_15_8 <= wr_data;
        7'd4:    pwm_duty_cycle  <= wr_data;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Readback path
  // -------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       tx_load;
  logic       tx_shift;
  logic       tx_active;
  logic [7:0] tx_reg;

  // shift_nxt holds the full header at the 8th rising edge.
  assign rd_addr = shift_nxt[6:0];

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr <= MAX_ADDR_L) begin
      case (rd_addr)
        7'd0:    rd_data = en_reg_out_7_0;
        7'd1:    rd_data = en_reg_out_15_8;
        7'd2:    rd_data = en_reg_pwm_7_0;
        7'd3:    rd_data = en_reg_pwm_15_8;
        7'd4:    rd_data = pwm_duty_cycle;
        default: rd_data = 8'h00;
      endcase
    end
  end

  assign tx_load = shift_en && (bit_cnt == 5'd7) && !shift_nxt[7];

  // The falling edge right after the 8th rise must not shift: the data MSB
  // has to stay on cipo until the controller samples it on the 9th rise.
  assign tx_shift = (state == ST_ACTIVE) && sclk_fall && tx_active &&
                    (bit_cnt >= 5'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active <= 1'b0;
      tx_reg    <= 8'h00;
    end else if (frame_start || frame_end) begin
      tx_active <= 1'b0;
      tx_reg    <= 8'h00;
    end else if (tx_load) begin
      tx_active <= 1'b1;
      tx_reg    <= rd_data;
    end else if (tx_shift) begin
      tx_reg <= {tx_reg[6:0], 1'b0};
    end
  end

  assign cipo = tx_active && (state == ST_ACTIVE) && tx_reg[7];
`else
  assign cipo = 1'b0;
`endif

endmodule
